// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } uart_rx_state_e;

  localparam int UART_DATA_BITS = 8;

  // Clocks per oversample tick, rounded to the nearest integer.
  function automatic int uart_div(input longint clk, input longint baud, input longint os);
    longint den;
    den = baud * os;
    return int'((clk + den / 2) / den);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock pulse every DIV clocks, re-phased by restart_i.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  if (DIV < 2) begin : g_bad_div
    $error("uart_baud_tick: DIV must be at least 2");
  end

  // Free-running divider; a restart pulls it back to zero so ticks align to the start edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (restart_i) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick_o = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling 8N1 UART receiver with a data/ready holding register and sticky error flags.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rxd_i,
  input  logic       rx_clear_i,
  output logic [7:0] rx_data_o,
  output logic       rx_ready_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       rx_idle_o
);

  localparam int DIV = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam int BW  = $clog2(UART_DATA_BITS);

  localparam logic [SW-1:0] S_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_EARLY = SW'(M - 1);
  localparam logic [SW-1:0] S_MID   = SW'(M);
  localparam logic [SW-1:0] S_LATE  = SW'(M + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);

  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("uart_rx_core: OVERSAMPLE must be even and at least 8");
  end

  logic rxd_meta;
  logic rxd_sync;
  logic rxd_prev;
  logic start_edge;
  logic restart;
  logic tick;

  uart_rx_state_e state;
  logic [SW-1:0]  s_cnt;
  logic [SW-1:0]  s_next;
  logic [BW-1:0]  bit_idx;
  logic           samp_early;
  logic           samp_mid;
  logic           majority;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic           stop_valid;
  logic           stop_bit;

  // Two-flop synchroniser plus a history flop for falling-edge detection; idles high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd_i;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  assign start_edge = rxd_prev & ~rxd_sync;
  assign restart    = (state == RX_IDLE) && start_edge;
  assign s_next     = (s_cnt == S_LAST) ? '0 : s_cnt + 1'b1;
  assign majority   = (samp_early & samp_mid) | (samp_early & rxd_sync) | (samp_mid & rxd_sync);

  uart_baud_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .restart_i(restart),
    .tick_o   (tick)
  );

  // Frame FSM: each tick advances the in-bit index; bit decisions land on the third mid-bit sample.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= RX_IDLE;
      s_cnt      <= '0;
      bit_idx    <= '0;
      samp_early <= 1'b1;
      samp_mid   <= 1'b1;
      shift_reg  <= '0;
      stop_valid <= 1'b0;
      stop_bit   <= 1'b0;
    end else begin
      stop_valid <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (start_edge) begin
            state <= RX_START;
            s_cnt <= '0;
          end
        end
        RX_START: begin
          if (tick) begin
            s_cnt <= s_next;
            if (s_next == S_LATE && majority) begin
              state <= RX_IDLE;
              s_cnt <= '0;
            end else if (s_cnt == S_LAST) begin
              state   <= RX_DATA;
              bit_idx <= '0;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            s_cnt <= s_next;
            if (s_next == S_LATE) begin
              shift_reg <= {majority, shift_reg[UART_DATA_BITS-1:1]};
            end
            if (s_cnt == S_LAST) begin
              if (bit_idx == BIT_LAST) begin
                state <= RX_STOP;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            s_cnt <= s_next;
            if (s_next == S_LATE) begin
              stop_valid <= 1'b1;
              stop_bit   <= majority;
              state      <= RX_IDLE;
              s_cnt      <= '0;
            end
          end
        end
        default: state <= RX_IDLE;
      endcase
      if (tick && state != RX_IDLE) begin
        if (s_next == S_EARLY) samp_early <= rxd_sync;
        if (s_next == S_MID)   samp_mid   <= rxd_sync;
      end
    end
  end

  // Commit one clock after the stop decision; a new byte or error outranks a same-cycle clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_data_o   <= '0;
      rx_ready_o  <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      if (rx_clear_i) begin
        rx_ready_o  <= 1'b0;
        frame_err_o <= 1'b0;
        overrun_o   <= 1'b0;
      end
      if (stop_valid) begin
        if (!stop_bit) begin
          frame_err_o <= 1'b1;
        end else if (!rx_ready_o || rx_clear_i) begin
          rx_data_o  <= shift_reg;
          rx_ready_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end
    end
  end

  assign rx_idle_o = (state == RX_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomised and directed bench for uart_rx_core with a queue-based scoreboard.
module tb_uart_rx_core;

  localparam int DIV      = 27;
  localparam int OS       = 16;
  localparam int BIT_CLKS = DIV * OS;
  localparam int FAST_BIT = (BIT_CLKS * 100) / 103;
  localparam int SLOW_BIT = (BIT_CLKS * 100) / 97;
  localparam int LAT      = DIV * (9 * OS + OS / 2 + 1) + 4;
  localparam int CLR_AT   = LAT + 35;

  logic       clk_i;
  logic       rst_ni;
  logic       rxd_i;
  logic       rx_clear_i;
  logic [7:0] rx_data_o;
  logic       rx_ready_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       rx_idle_o;

  int total;
  int bad;

  // Expected output vectors {data, ready, frame_err, overrun}, one per visible change.
  logic [10:0] exp_q[$];
  string       name_q[$];

  logic [7:0]  m_data;
  logic        m_ready;
  logic        m_fe;
  logic        m_ov;
  logic [10:0] m_last;

  logic        mon_on;
  logic        lat_armed;
  longint      start_time;

  uart_rx_core dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rxd_i      (rxd_i),
    .rx_clear_i (rx_clear_i),
    .rx_data_o  (rx_data_o),
    .rx_ready_o (rx_ready_o),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
    .rx_idle_o  (rx_idle_o)
  );

  // Free-running system clock.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic model_push(input string name);
    logic [10:0] v;
    v = {m_data, m_ready, m_fe, m_ov};
    if (v != m_last) begin
      exp_q.push_back(v);
      name_q.push_back(name);
      m_last = v;
    end
  endtask

  task automatic model_frame(input logic [7:0] data, input logic stop_ok, input string name);
    if (!stop_ok) begin
      m_fe = 1'b1;
    end else if (!m_ready) begin
      m_data  = data;
      m_ready = 1'b1;
    end else begin
      m_ov = 1'b1;
    end
    model_push(name);
  endtask

  task automatic model_clear(input string name);
    m_ready = 1'b0;
    m_fe    = 1'b0;
    m_ov    = 1'b0;
    model_push(name);
  endtask

  task automatic model_reset(input string name);
    m_data  = 8'h00;
    m_ready = 1'b0;
    m_fe    = 1'b0;
    m_ov    = 1'b0;
    model_push(name);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
      rxd_i      = 1'b1;
      rx_clear_i = 1'b0;
    end
  endtask

  task automatic pulse_clear(input string name);
    model_clear(name);
    @(posedge clk_i);
    #1;
    rx_clear_i = 1'b1;
    @(posedge clk_i);
    #1;
    rx_clear_i = 1'b0;
  endtask

  // Drive one 8N1 frame; optionally clear after the commit, or abandon it after cut_at clocks.
  task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit, input int bit_clks,
                                input logic do_clear, input int cut_at, input string name);
    logic [9:0] bits;
    int total_clks;
    bits = {stop_bit, data, 1'b0};
    total_clks = 10 * bit_clks;
    if (cut_at == 0) begin
      model_frame(data, stop_bit, name);
      if (do_clear) model_clear({name, "_clr"});
    end
    for (int c = 0; c < total_clks; c++) begin
      if (cut_at != 0 && c == cut_at) return;
      @(posedge clk_i);
      #1;
      if (c == 0) start_time = longint'($time);
      rxd_i      = bits[c / bit_clks];
      rx_clear_i = do_clear && (c == CLR_AT);
    end
    if (!stop_bit) idle_cycles(bit_clks);
    @(posedge clk_i);
    #1;
    rxd_i      = 1'b1;
    rx_clear_i = 1'b0;
  endtask

  // Monitor: every visible output change must match the next expected vector.
  initial begin
    logic [10:0] cur;
    logic [10:0] last_seen;
    logic [10:0] e;
    string       n;
    longint      lat;
    last_seen = '0;
    wait (mon_on);
    forever begin
      @(negedge clk_i);
      cur = {rx_data_o, rx_ready_o, frame_err_o, overrun_o};
      if (cur !== last_seen) begin
        if (lat_armed && cur[2] && !last_seen[2]) begin
          lat = (longint'($time) - start_time + 5) / 10;
          total++;
          if (lat < LAT - 1 || lat > LAT + 1) begin
            bad++;
            $display("[TB] FAIL latency: got %0d clocks expected %0d (+/-1)", lat, LAT);
          end
          lat_armed = 1'b0;
        end
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_change: got 0x%0h expected no change from 0x%0h", cur, last_seen);
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
          check_output(n, 32'(cur), 32'(e));
        end
        last_seen = cur;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  // Stimulus sequence.
  initial begin
    int n;
    total = 0;
    bad = 0;
    m_data = '0; m_ready = 1'b0; m_fe = 1'b0; m_ov = 1'b0; m_last = '0;
    mon_on = 1'b0;
    lat_armed = 1'b0;
    start_time = 0;
    rst_ni = 1'b0;
    rxd_i = 1'b1;
    rx_clear_i = 1'b0;

    repeat (5) @(negedge clk_i);
    check_output("reset_data", 32'(rx_data_o), 32'h0);
    check_output("reset_ready", 32'(rx_ready_o), 32'h0);
    check_output("reset_frame_err", 32'(frame_err_o), 32'h0);
    check_output("reset_overrun", 32'(overrun_o), 32'h0);
    check_output("reset_idle", 32'(rx_idle_o), 32'h1);
    mon_on = 1'b1;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    idle_cycles(20);

    $display("[TB] test 1: good frame 0x55 and clear");
    lat_armed = 1'b1;
    apply_stimulus(8'h55, 1'b1, BIT_CLKS, 1'b0, 0, "t1_frame_55");
    pulse_clear("t1_clear");
    check_output("t1_ready_after_clear", 32'(rx_ready_o), 32'h0);
    idle_cycles(20);

    $display("[TB] test 2: false start");
    for (int c = 0; c < 100; c++) begin
      @(posedge clk_i);
      #1;
      rxd_i = 1'b0;
      if (c == 50) check_output("t2_left_idle", 32'(rx_idle_o), 32'h0);
    end
    @(posedge clk_i);
    #1;
    rxd_i = 1'b1;
    n = 0;
    while (!rx_idle_o && n < BIT_CLKS) begin
      @(negedge clk_i);
      n++;
    end
    check_output("t2_back_to_idle", 32'(rx_idle_o), 32'h1);
    idle_cycles(BIT_CLKS);

    $display("[TB] test 3: bad stop bit");
    apply_stimulus(8'hA3, 1'b0, BIT_CLKS, 1'b0, 0, "t3_frame_a3");
    pulse_clear("t3_clear");
    idle_cycles(20);

    $display("[TB] test 4: overrun");
    apply_stimulus(8'h12, 1'b1, BIT_CLKS, 1'b0, 0, "t4_frame_12");
    idle_cycles(10);
    apply_stimulus(8'h34, 1'b1, BIT_CLKS, 1'b0, 0, "t4_frame_34");
    pulse_clear("t4_clear");
    check_output("t4_ready_after_clear", 32'(rx_ready_o), 32'h0);
    check_output("t4_overrun_after_clear", 32'(overrun_o), 32'h0);
    idle_cycles(20);

    $display("[TB] test 5: back-to-back frames at +/-3%% rate");
    apply_stimulus(8'h00, 1'b1, FAST_BIT, 1'b1, 0, "t5_fast_00");
    apply_stimulus(8'hFF, 1'b1, FAST_BIT, 1'b1, 0, "t5_fast_ff");
    apply_stimulus(8'h81, 1'b1, FAST_BIT, 1'b1, 0, "t5_fast_81");
    apply_stimulus(8'h00, 1'b1, SLOW_BIT, 1'b1, 0, "t5_slow_00");
    apply_stimulus(8'hFF, 1'b1, SLOW_BIT, 1'b1, 0, "t5_slow_ff");
    apply_stimulus(8'h81, 1'b1, SLOW_BIT, 1'b1, 0, "t5_slow_81");
    idle_cycles(20);

    $display("[TB] random frames");
    for (int i = 0; i < 3; i++) begin
      logic [7:0] b;
      logic       sb;
      logic       cl;
      b  = 8'($urandom_range(0, 255));
      sb = (i == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
      cl = (i == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      apply_stimulus(b, sb, BIT_CLKS, cl, 0, $sformatf("rand_%0d_%02h_s%0d", i, b, sb));
      idle_cycles(1 + $urandom_range(0, 40));
    end

    $display("[TB] test 6: reset mid-frame");
    apply_stimulus(8'hC3, 1'b1, BIT_CLKS, 1'b0, (BIT_CLKS * 11) / 2, "t6_cut");
    model_reset("t6_reset");
    rst_ni = 1'b0;
    rxd_i  = 1'b1;
    #1;
    check_output("t6_rst_data", 32'(rx_data_o), 32'h0);
    check_output("t6_rst_ready", 32'(rx_ready_o), 32'h0);
    check_output("t6_rst_frame_err", 32'(frame_err_o), 32'h0);
    check_output("t6_rst_overrun", 32'(overrun_o), 32'h0);
    check_output("t6_rst_idle", 32'(rx_idle_o), 32'h1);
    repeat (5) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    idle_cycles(20);
    apply_stimulus(8'hC3, 1'b1, BIT_CLKS, 1'b0, 0, "t6_frame_c3");
    idle_cycles(50);

    check_output("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
